fork_join_ctrl: RTL and testbench
=================================

Name: fork_join_ctrl

Overview:
- Hardware fork/join controller: on one start request it launches NUM_JOBS parallel workers with a common start pulse (fork).
- It then collects their done pulses and signals completion according to a join mode: ALL, ANY or NONE.
- Sits between a sequencing master and a bank of independent worker engines.
- Provides a cycle-accurate elapsed count, a per-worker completion mask and a watchdog timeout.

Parameters:
- NUM_JOBS, 3, number of parallel worker lanes (1..16).
- CNT_W, 16, width of the elapsed-cycle counter.
- TIMEOUT, 1000, WAIT cycles before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  launch request; honoured only in IDLE.
- mode_i  in  2  join mode: 00 ALL, 01 ANY, 10 NONE, 11 treated as ALL; sampled with start_i.
- worker_start_o  out  NUM_JOBS  one-cycle launch pulse, all bits together.
- worker_done_i  in  NUM_JOBS  per-worker done pulse or level; sampled only in WAIT.
- busy_o  out  1  high in LAUNCH, WAIT, DONE.
- join_done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  one-cycle pulse, coincident with join_done_o when the watchdog fired.
- done_mask_o  out  NUM_JOBS  sticky record of workers finished this run.
- elapsed_o  out  CNT_W  cycles spent in WAIT this run; saturating.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; mode register=ALL.
- States are IDLE, LAUNCH, WAIT, DONE.
- IDLE: start_i=1 -> LAUNCH. This also latches mode_i, clears done_mask_o and elapsed_o, and clears mode-NONE signalled flag. Outputs from the previous run are held until then.
- LAUNCH (exactly 1 cycle):
  - worker_start_o = all ones.
  - worker_done_i is ignored in this cycle.
  - In mode NONE, join_done_o=1 in this cycle.
  - Next state is WAIT.
- WAIT:
  - Each cycle: done_mask_o <= done_mask_o | worker_done_i.
  - elapsed_o increments, saturating at all ones.
  - Join condition uses the updated mask (mask | worker_done_i):
    - ALL: every bit set.
    - ANY: at least one bit set.
    - NONE: every bit set, i.e. wait for background drain.
  - Condition true -> DONE.
  - Else if TIMEOUT!=0 and elapsed_o == TIMEOUT-1 this cycle -> DONE with timeout flag.
  - Join condition has priority over timeout in the same cycle.
- DONE (exactly 1 cycle):
  - join_done_o=1, except in mode NONE, where the pulse already fired in LAUNCH.
  - timeout_o=1 if the timeout flag is set; this applies in NONE as well.
  - Mask and elapsed are frozen. Next state is IDLE.
- Latency:
  - start_i at cycle 0 -> worker_start_o at cycle 1 -> first done sampled at cycle 2.
  - Join condition met at cycle k -> join_done_o at cycle k+1.
- Mode ANY: workers still running after DONE are not tracked. Late done pulses in IDLE are ignored; the mask is not updated.
- start_i while busy_o=1 is ignored and not queued.
- Simultaneous done on multiple lanes in one cycle is all captured.
- Reset mid-run: immediate return to IDLE, outputs 0, no join_done_o pulse.

Decomposition:
- Shared package fork_join_pkg holds:
  - typedef enum join_mode_e {JOIN_ALL, JOIN_ANY, JOIN_NONE}.
  - typedef enum fj_state_e {IDLE, LAUNCH, WAIT, DONE}.
  - Constant MODE_W=2.
- One natural sub-module, fj_sat_counter: parameterised saturating counter with clear and enable, used for elapsed_o and the watchdog compare.

Test Plan:
- Mode ALL, N=3, dones on lanes 1, 0, 2 at cycles 5, 12, 22 after start -> join_done_o at cycle 23 only; done_mask_o=3'b111; elapsed_o=21; timeout_o=0.
- Mode ANY, lane 2 done at cycle 11 -> join_done_o at cycle 12; done_mask_o=3'b100; later dones on lanes 0/1 leave the mask at 3'b100.
- Mode NONE -> join_done_o high in the same cycle as worker_start_o (cycle 1). busy_o stays 1 until all 3 lanes done (last at cycle 30). It falls at cycle 32 with no second join_done_o.
- TIMEOUT=50, mode ALL, lane 1 never completes -> join_done_o and timeout_o both pulse exactly once at cycle 52; done_mask_o=3'b101; elapsed_o=50.
- start_i pulsed in WAIT, plus worker_done_i asserted during LAUNCH -> no relaunch; the LAUNCH-cycle done is not in the mask.
- rst_n asserted mid-WAIT -> all outputs 0 asynchronously. A start after release runs normally from IDLE.

Source files
------------

// File: rtl/fork_join_pkg.sv
// fork_join_pkg: shared types and helpers for the fork/join controller.
//   join_mode_e : completion policy (ALL, ANY, NONE)
//   fj_state_e  : controller FSM states
//   MODE_W      : width of the mode_i port
//   decode_mode : maps the raw mode field onto join_mode_e (11 -> ALL)
package fork_join_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        JOIN_ALL  = 2'b00,
        JOIN_ANY  = 2'b01,
        JOIN_NONE = 2'b10
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } fj_state_e;

    function automatic join_mode_e decode_mode(input logic [MODE_W-1:0] m);
        case (m)
            2'b01:   return JOIN_ANY;
            2'b10:   return JOIN_NONE;
            default: return JOIN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/fj_sat_counter.sv
// fj_sat_counter: up-counter that sticks at all ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count enable
//   cnt_o      : current count
module fj_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: launches NUM_JOBS workers with one common start pulse,
// then collects their done pulses and reports completion per join mode.
//   start_i        : launch request, honoured only in IDLE
//   mode_i         : join mode, sampled with start_i (00 ALL, 01 ANY, 10 NONE, 11 ALL)
//   worker_start_o : one-cycle launch pulse to every lane
//   worker_done_i  : per-lane done, sampled only in WAIT
//   busy_o         : high in LAUNCH, WAIT, DONE
//   join_done_o    : one-cycle completion pulse
//   timeout_o      : one-cycle pulse alongside completion when the watchdog fired
//   done_mask_o    : sticky record of lanes finished this run
//   elapsed_o      : saturating count of WAIT cycles this run
module fork_join_ctrl
    import fork_join_pkg::*;
#(
    parameter int unsigned NUM_JOBS = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [MODE_W-1:0]   mode_i,
    output logic [NUM_JOBS-1:0] worker_start_o,
    input  logic [NUM_JOBS-1:0] worker_done_i,
    output logic                busy_o,
    output logic                join_done_o,
    output logic                timeout_o,
    output logic [NUM_JOBS-1:0] done_mask_o,
    output logic [CNT_W-1:0]    elapsed_o
);

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    fj_state_e             state_q, state_d;
    join_mode_e            mode_q, mode_d;
    logic [NUM_JOBS-1:0]   mask_q, mask_d;
    logic                  tmo_q, tmo_d;
    logic                  launch;
    logic                  join_hit;
    logic [CNT_W-1:0]      elapsed;

    assign launch = (state_q == IDLE) && start_i;

    fj_sat_counter #(
        .W (CNT_W)
    ) u_elapsed (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (launch),
        .en_i  (state_q == WAIT),
        .cnt_o (elapsed)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        tmo_d    = tmo_q;
        join_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LAUNCH;
                    mode_d  = decode_mode(mode_i);
                    mask_d  = '0;
                    tmo_d   = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                mask_d = mask_q | worker_done_i;
                // NONE waits for every lane too; its pulse already went out in LAUNCH.
                join_hit = (mode_q == JOIN_ANY) ? (|mask_d) : (&mask_d);
                if (join_hit) begin
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (elapsed == TO_LAST)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= JOIN_ALL;
            mask_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
        end
    end

    assign worker_start_o = {NUM_JOBS{state_q == LAUNCH}};
    assign busy_o         = (state_q != IDLE);
    assign join_done_o    = ((state_q == LAUNCH) && (mode_q == JOIN_NONE)) ||
                            ((state_q == DONE)   && (mode_q != JOIN_NONE));
    assign timeout_o      = (state_q == DONE) && tmo_q;
    assign done_mask_o    = mask_q;
    assign elapsed_o      = elapsed;

endmodule

// File: tb/tb_fork_join_ctrl.sv
module tb_fork_join_ctrl;

    localparam int unsigned NJ = 3;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [NJ-1:0] worker_done_i = '0;
    logic [NJ-1:0] worker_start_o;
    logic          busy_o;
    logic          join_done_o;
    logic          timeout_o;
    logic [NJ-1:0] done_mask_o;
    logic [CW-1:0] elapsed_o;

    typedef struct {
        int   cyc;
        logic tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fork_join_ctrl #(
        .NUM_JOBS (NJ),
        .CNT_W    (CW),
        .TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .worker_start_o (worker_start_o),
        .worker_done_i  (worker_done_i),
        .busy_o         (busy_o),
        .join_done_o    (join_done_o),
        .timeout_o      (timeout_o),
        .done_mask_o    (done_mask_o),
        .elapsed_o      (elapsed_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int cyc, input logic tmo);
        exp_t e;
        e.cyc = cyc;
        e.tmo = tmo;
        sb.push_back(e);
    endtask

    // One relative cycle of a run: launch pulse, busy and the scoreboarded completion pulse.
    task automatic check_cycle(input int c, input int exp_end);
        exp_t        e;
        logic [NJ-1:0] exp_ws;
        exp_ws = (c == 1) ? '1 : '0;
        checks++;
        if (worker_start_o !== exp_ws) begin
            errors++;
            $display("FAIL worker_start c=%0d: got %b expected %b", c, worker_start_o, exp_ws);
        end
        checks++;
        if (busy_o !== (c >= 1 && c <= exp_end)) begin
            errors++;
            $display("FAIL busy c=%0d: got %b expected %b", c, busy_o, (c >= 1 && c <= exp_end));
        end
        if (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if ({join_done_o, timeout_o} !== {1'b1, e.tmo}) begin
                errors++;
                $display("FAIL join_pulse c=%0d: got join=%b tmo=%b expected join=1 tmo=%b",
                         c, join_done_o, timeout_o, e.tmo);
            end
        end else begin
            checks++;
            if ({join_done_o, timeout_o} !== 2'b00) begin
                errors++;
                $display("FAIL spurious_pulse c=%0d: got join=%b tmo=%b expected 0 0",
                         c, join_done_o, timeout_o);
            end
        end
    endtask

    // Drives one run from the current cycle (cycle 0 = start_i high). Lane done pulses
    // at cycles d0/d1/d2 (0 = never). Returns in cycle ncyc.
    task automatic run_job(input logic [1:0] mode, input int d0, input int d1, input int d2,
                           input int ncyc, input int exp_end, input int start_again,
                           input logic launch_done, input int probe_cyc,
                           input logic [NJ-1:0] probe_mask, input logic abort);
        mode_i        = mode;
        start_i       = 1'b1;
        worker_done_i = '0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            check_cycle(c, exp_end);
            if (c == probe_cyc) begin
                checks++;
                if (done_mask_o !== probe_mask) begin
                    errors++;
                    $display("FAIL probe_mask c=%0d: got %b expected %b", c, done_mask_o, probe_mask);
                end
            end
            start_i       = (c == start_again);
            worker_done_i = '0;
            if (c == d0) worker_done_i[0] = 1'b1;
            if (c == d1) worker_done_i[1] = 1'b1;
            if (c == d2) worker_done_i[2] = 1'b1;
            if (c == 1 && launch_done) worker_done_i = '1;
        end
        start_i       = 1'b0;
        worker_done_i = '0;
        if (!abort) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL missing_pulse: got %0d pending expected 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic check_result(input string name, input logic [NJ-1:0] mask, input int el);
        checks++;
        if (done_mask_o !== mask) begin
            errors++;
            $display("FAIL %s_mask: got %b expected %b", name, done_mask_o, mask);
        end
        checks++;
        if (elapsed_o !== CW'(el)) begin
            errors++;
            $display("FAIL %s_elapsed: got %0d expected %0d", name, elapsed_o, el);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({worker_start_o, busy_o, join_done_o, timeout_o, done_mask_o, elapsed_o} !== '0) begin
            errors++;
            $display("FAIL %s: got ws=%b busy=%b join=%b tmo=%b mask=%b el=%0d expected all 0",
                     name, worker_start_o, busy_o, join_done_o, timeout_o, done_mask_o, elapsed_o);
        end
    endtask

    task automatic test_reset();
        #23;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_released");
    endtask

    task automatic test_all();
        push_exp(23, 1'b0);
        run_job(2'b00, 12, 5, 22, 28, 23, 0, 1'b0, 13, 3'b011, 1'b0);
        check_result("all", 3'b111, 21);
    endtask

    task automatic test_any();
        push_exp(12, 1'b0);
        run_job(2'b01, 15, 20, 11, 25, 12, 0, 1'b0, 0, '0, 1'b0);
        check_result("any", 3'b100, 10);
    endtask

    task automatic test_none();
        push_exp(1, 1'b0);
        run_job(2'b10, 10, 20, 30, 35, 31, 0, 1'b0, 21, 3'b011, 1'b0);
        check_result("none", 3'b111, 29);
    endtask

    task automatic test_timeout();
        push_exp(52, 1'b1);
        run_job(2'b00, 5, 0, 8, 55, 52, 0, 1'b0, 0, '0, 1'b0);
        check_result("timeout", 3'b101, 50);
    endtask

    task automatic test_ignore_start_and_launch_done();
        push_exp(10, 1'b0);
        run_job(2'b00, 6, 7, 9, 14, 10, 4, 1'b1, 5, 3'b000, 1'b0);
        check_result("ignore", 3'b111, 8);
    endtask

    task automatic test_mode_default();
        push_exp(7, 1'b0);
        run_job(2'b11, 3, 6, 6, 9, 7, 0, 1'b0, 0, '0, 1'b0);
        check_result("mode11", 3'b111, 5);
    endtask

    task automatic test_back_to_back();
        push_exp(4, 1'b0);
        run_job(2'b00, 3, 3, 3, 5, 4, 0, 1'b0, 0, '0, 1'b0);
        check_result("b2b_first", 3'b111, 2);
        push_exp(3, 1'b0);
        run_job(2'b01, 2, 0, 0, 6, 3, 0, 1'b0, 0, '0, 1'b0);
        check_result("b2b_second", 3'b001, 1);
    endtask

    task automatic test_reset_mid();
        run_job(2'b00, 5, 0, 0, 8, 1000, 0, 1'b0, 0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_mid_released");
        push_exp(6, 1'b0);
        run_job(2'b00, 3, 4, 5, 8, 6, 0, 1'b0, 0, '0, 1'b0);
        check_result("after_reset", 3'b111, 4);
    endtask

    initial begin
        test_reset();
        test_all();
        test_any();
        test_none();
        test_timeout();
        test_ignore_start_and_launch_done();
        test_mode_default();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
